// File: rtl/featuremap_pad_scheduler.sv
// featuremap_pad_scheduler
//   Walks a zero-padded (HEIGHT+2) x (WIDTH+2) frame in raster order and feeds
//   the shared 8-channel sample bus of the featuremap filters. Border positions
//   emit zeros. Interior positions pop all eight channel FIFOs in lockstep.
//   Filter results are counted, and frame completion is reported with a done
//   pulse.
//
//   Optional feature: define PAD_SCHED_STALL_CNT_EN to enable the saturating
//   stall counter. When it is undefined, stall_cycles is tied to zero.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   start           one-cycle frame start; honoured only in IDLE
//   fifo_data       8 show-ahead channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fifo_empty      per-channel empty flags
//   fm_valid        one pulse per filter result
//   rdreq           common pop to all 8 FIFOs (combinational)
//   data_out        registered sample bus
//   valid_out       registered sample strobe
//   busy, done      frame in progress / one-cycle frame-end pulse
//   stall_cycles    interior cycles lost to an empty FIFO
module featuremap_pad_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*DATA_WIDTH-1:0] fifo_data,
    input  logic [7:0]              fifo_empty,
    input  logic                    fm_valid,
    output logic                    rdreq,
    output logic [8*DATA_WIDTH-1:0] data_out,
    output logic                    valid_out,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             stall_cycles
);

    localparam int RW = $clog2(HEIGHT + 2);
    localparam int CW = $clog2(WIDTH + 2);
    localparam int NW = $clog2(WIDTH * HEIGHT + 1);
    localparam logic [RW-1:0] R_LAST = RW'(HEIGHT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH + 1);
    localparam logic [NW-1:0] N_TOT  = NW'(WIDTH * HEIGHT);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [NW-1:0] res_cnt;
    logic          border, fifo_ok, last_pos;
    logic          emit, stall, start_acc, counting;

    assign border   = (r == '0) || (r == R_LAST) || (c == '0) || (c == C_LAST);
    assign fifo_ok  = (fifo_empty == 8'h00);
    assign last_pos = (r == R_LAST) && (c == C_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = STREAM;
            STREAM: if (emit && last_pos) state_nxt = DRAIN;
            DRAIN:  if (res_cnt == N_TOT) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        start_acc = (state == IDLE) && start;
        emit      = (state == STREAM) && (border || fifo_ok);
        stall     = (state == STREAM) && !border && !fifo_ok;
        rdreq     = (state == STREAM) && !border && fifo_ok;
        counting  = (state == STREAM) || (state == DRAIN);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end

    // Raster position; only moves when a sample is emitted, so a stall holds it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= '0;
            c <= '0;
        end else if (start_acc) begin
            r <= '0;
            c <= '0;
        end else if (emit) begin
            if (c == C_LAST) begin
                c <= '0;
                r <= last_pos ? '0 : r + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    // Sample register; data holds while valid_out is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= emit;
            if (emit) data_out <= border ? '0 : fifo_data;
        end
    end

    // Result counter saturates at the frame size so stray pulses cannot wrap it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        res_cnt <= '0;
        else if (start_acc)                              res_cnt <= '0;
        else if (counting && fm_valid && res_cnt != N_TOT) res_cnt <= res_cnt + 1'b1;
    end

`ifdef PAD_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               stall_cycles <= '0;
        else if (start_acc)                     stall_cycles <= '0;
        else if (stall && stall_cycles != '1)   stall_cycles <= stall_cycles + 1'b1;
    end
`else
    assign stall_cycles = '0;
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule

// File: tb/tb_featuremap_pad_scheduler.sv
// Randomized bench for featuremap_pad_scheduler. The reference is a raster
// list of expected samples built from the padded-frame rules and a simple FIFO
// model (array plus read pointer); DUT output is collected and compared.
module tb_featuremap_pad_scheduler;
    localparam int DW   = 32;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int BUS  = 8 * DW;
    localparam int NPIX = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, fm_valid;
    logic [7:0]     force_mask;
    logic [BUS-1:0] pix [NPIX];
    int             ptr = 0;
    logic [BUS-1:0] fifo_data;
    logic [7:0]     fifo_empty;
    logic           rdreq, valid_out, busy, done;
    logic [BUS-1:0] data_out;
    logic [31:0]    stall_cycles;

    assign fifo_data  = pix[ptr];
    assign fifo_empty = force_mask;

    // FIFO model: a pop advances the read pointer on the clock edge
    always @(posedge clk) if (rdreq) ptr <= ptr + 1;

    featuremap_pad_scheduler #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fm_valid(fm_valid), .rdreq(rdreq),
        .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done),
        .stall_cycles(stall_cycles));

    // 1x1 instance
    logic           start1, fm_valid1, rdreq1, valid_out1, busy1, done1;
    logic [BUS-1:0] fd1, data_out1;
    logic [7:0]     fe1;
    logic [31:0]    stall1;

    featuremap_pad_scheduler #(.DATA_WIDTH(DW), .WIDTH(1), .HEIGHT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .fifo_data(fd1),
        .fifo_empty(fe1), .fm_valid(fm_valid1), .rdreq(rdreq1),
        .data_out(data_out1), .valid_out(valid_out1), .busy(busy1), .done(done1),
        .stall_cycles(stall1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdreq"}, rdreq, 0);
        chk({tag, "_valid"}, valid_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stall"}, stall_cycles, 0);
    endtask

    // One frame on the 4x4 instance.
    //   n_stream : fm_valid pulses issued back-to-back once streaming starts
    //   n_late   : fm_valid pulses issued after the last sample, random gaps
    //   starve   : hold channel 3 empty for 5 cycles at position (2,2)
    //   glitch   : pulse start mid-stream and in the done cycle
    //   rst_at   : >0 pulls reset once that many samples have been seen
    task automatic run_frame(input int n_stream, input int n_late, input bit starve,
                             input bit glitch, input int rst_at);
        logic [BUS-1:0] expq[$];
        logic [BUS-1:0] got[$];
        logic [BUS-1:0] last;
        int base, k, t36, done_step, exp_done, dones, rd_cnt, gaps;
        int pulses, late_left, next_late, starve_left, viol, exp_stall;
        bit starve_done;

        base = ptr;
        k = 0;
        for (int r = 0; r < H + 2; r++)
            for (int c = 0; c < W + 2; c++)
                if (r == 0 || r == H + 1 || c == 0 || c == W + 1) expq.push_back('0);
                else begin
                    expq.push_back(pix[base + k]);
                    k++;
                end

        t36 = -1; done_step = -1; exp_done = -1; next_late = -1;
        dones = 0; rd_cnt = 0; gaps = 0; pulses = 0; viol = 0;
        late_left = n_late; starve_left = 0; starve_done = 0; last = '0;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_not_yet", valid_out, 0);

        for (int step = 0; step < 600; step++) begin
            @(negedge clk);
            start    = 1'b0;
            fm_valid = 1'b0;

            if (rdreq && (fifo_empty != 8'h00 || !busy)) viol++;
            if (rdreq) rd_cnt++;
            if (valid_out) begin
                got.push_back(data_out);
                last = data_out;
            end else if (got.size() > 0 && got.size() < 36) begin
                gaps++;
                if (data_out !== last) viol++;
            end
            if (done) begin
                dones++;
                if (done_step < 0) done_step = step;
                if (glitch) start = 1'b1;
            end
            if (done_step >= 0 && step == done_step + 1) begin
                chk("busy_falls", busy, 0);
                chk("done_one_cycle", done, 0);
            end

            if (rst_at > 0 && got.size() == rst_at) begin
                rst = 1'b0;
                #1;
                chk_reset_outputs("midframe_reset");
                chk("midframe_reset_busy1", busy1, 0);
                @(negedge clk) rst = 1'b1;
                return;
            end

            if (starve && !starve_done && ptr - base == 5) begin
                starve_left = 5;
                starve_done = 1;
            end
            force_mask = (starve_left > 0) ? 8'h08 : 8'h00;
            if (starve_left > 0) starve_left--;

            if (glitch && got.size() == 10 && valid_out) start = 1'b1;
            if (got.size() >= 1 && pulses < n_stream) begin
                fm_valid = 1'b1;
                pulses++;
            end
            if (got.size() == 36 && t36 < 0) begin
                t36 = step;
                if (n_late == 0) exp_done = step + 1;
                else             next_late = step + 3;
            end
            if (next_late == step && late_left > 0) begin
                fm_valid = 1'b1;
                late_left--;
                if (late_left == 0) exp_done = step + 2;
                else                next_late = step + 1 + int'($urandom_range(1, 3));
            end
            if (done_step >= 0 && step >= done_step + 3) break;
        end
        force_mask = 8'h00;
        fm_valid   = 1'b0;
        start      = 1'b0;

`ifdef PAD_SCHED_STALL_CNT_EN
        exp_stall = starve ? 5 : 0;
`else
        exp_stall = 0;
`endif
        chk("frame_done_seen", done_step >= 0, 1);
        chk("sample_count", got.size(), 36);
        for (int i = 0; i < got.size() && i < 36; i++) chk($sformatf("sample[%0d]", i), got[i], expq[i]);
        chk("rdreq_count", rd_cnt, 16);
        chk("valid_gaps", gaps, starve ? 5 : 0);
        chk("protocol_violations", viol, 0);
        chk("done_count", dones, 1);
        chk("done_timing", done_step, exp_done);
        chk("stall_cycles", stall_cycles, exp_stall);
        chk("idle_after_frame", busy, 0);
    endtask

    task automatic run_small();
        logic [BUS-1:0] got[$];
        int rd_cnt, dones, done_step, s9;
        rd_cnt = 0; dones = 0; done_step = -1; s9 = -1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int step = 0; step < 100; step++) begin
            @(negedge clk);
            fm_valid1 = 1'b0;
            if (rdreq1) begin
                rd_cnt++;
                fm_valid1 = 1'b1;
            end
            if (valid_out1) got.push_back(data_out1);
            if (got.size() == 9 && s9 < 0) s9 = step;
            if (done1) begin
                dones++;
                if (done_step < 0) done_step = step;
            end
            if (done_step >= 0 && step >= done_step + 2) break;
        end
        fm_valid1 = 1'b0;
        chk("small_samples", got.size(), 9);
        for (int i = 0; i < got.size() && i < 9; i++)
            chk($sformatf("small_sample[%0d]", i), got[i], (i == 4) ? fd1 : '0);
        chk("small_rdreq", rd_cnt, 1);
        chk("small_done_count", dones, 1);
        chk("small_done_timing", done_step, s9 + 1);
        chk("small_idle", busy1, 0);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++)
            for (int ch = 0; ch < 8; ch++) pix[i][ch*DW +: DW] = $urandom;
        rst = 1'b0; start = 1'b0; fm_valid = 1'b0; force_mask = 8'h00;
        start1 = 1'b0; fm_valid1 = 1'b0; fe1 = 8'h00;
        fd1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        run_frame(16, 0, 0, 0, 0);   // stall-free
        run_frame(16, 0, 1, 0, 0);   // starved interior
        run_frame(10, 6, 0, 0, 0);   // late results
        run_frame(20, 0, 0, 0, 0);   // extra results saturate the counter
        run_frame(16, 0, 0, 1, 0);   // start glitches ignored
        run_frame(16, 0, 0, 0, 19);  // reset at (3,1)
        run_frame(16, 0, 0, 0, 0);   // fresh frame after reset
        run_small();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
